md_sequencer: RTL and testbench
===============================

// Module: md_sequencer
// PURPOSE
//  Multi-cycle multiply/divide controller in the E stage of the 5-stage MIPS pipeline.
//  - Accepts mult/multu/div/divu/mthi/mtlo from E and counts out the op latency.
//  - Owns the HI/LO registers.
//  - Raises stall_req so the hazard unit freezes F/D and bubbles E while a HI/LO user waits.
// PARAMETERS
//  MULT_CYCLES  5   busy cycles for mult/multu (>=1)
//  DIV_CYCLES   10  busy cycles for div/divu (>=1)
// PORTS
//  clk        in   1   system clock, all state on posedge
//  reset      in   1   synchronous, active-high; clears all state
//  start      in   1   E-stage instr is an MD op this cycle
//  op         in   3   0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo; 6-7 no-op
//  a          in   32  rs operand (forwarded)
//  b          in   32  rt operand (forwarded)
//  md_use_E   in   1   E-stage instr reads or writes HI/LO (mf*/mt*/mult*/div*)
//  cancel     in   1   abort in-flight op (only with MD_CANCEL_EN)
//  busy       out  1   op in flight
//  stall_req  out  1   md_use_E & (busy | (start & op<=3)), combinational
//  done       out  1   1-cycle pulse on the edge HI/LO take a mult/div result
//  hi         out  32  HI register
//  lo         out  32  LO register
// BEHAVIOUR
//  - Reset: busy=0, done=0, hi=0, lo=0, cnt=0, state=IDLE. Any in-flight op is dropped.
//  - FSM IDLE:
//    - start & op<=3: latch a, b, op; load cnt = N-1 (N=MULT_CYCLES or DIV_CYCLES); go BUSY.
//    - start & op 4/5: write a to hi/lo next edge; stay IDLE; no busy, no done.
//    - start & op 6/7: ignored.
//  - FSM BUSY:
//    - busy=1. cnt decrements each cycle.
//    - At cnt==0 edge: write hi/lo, pulse done, go IDLE.
//    - Latency: start at edge k -> hi/lo valid after edge k+N; busy high for exactly N cycles.
//  - start during BUSY: ignored. The pipeline cannot issue one because stall_req holds the
//    instr in E; the bench flags it as an error.
//  - Back-to-back: start in the cycle after done is accepted normally.
//  - Arithmetic (result computed from latched operands, committed only at end):
//    - mult: {hi,lo} = $signed(a) * $signed(b), 64 bit. multu: unsigned 64-bit product.
//    - div: lo = quotient truncated toward zero; hi = remainder with the sign of a.
//    - divu: unsigned quotient/remainder.
//    - b==0 (div/divu): hi/lo unchanged, done still pulses, full DIV_CYCLES latency.
//    - div 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0 (no trap).
//  - Reset mid-BUSY: abort; hi/lo=0; the next start is accepted the cycle after reset
//    deasserts.
// CONFIGURATION
//  MD_CANCEL_EN defined:
//    - cancel=1 in BUSY -> IDLE next edge; hi/lo keep their pre-op values; no done pulse.
//    - cancel=1 with start in IDLE (same cycle): start is suppressed; mthi/mtlo also dropped.
//    - cancel has priority over cnt==0 completion in the same cycle.
//  MD_CANCEL_EN undefined:
//    - cancel port absent; ops always run to completion.
// TESTING
//  - mult a=0xFFFFFFFE(-2), b=3 -> busy 5 cycles; done on edge 5; hi=0xFFFFFFFF, lo=0xFFFFFFFA.
//  - multu a=0xFFFFFFFF, b=2 -> hi=0x00000001, lo=0xFFFFFFFE.
//  - div a=-7, b=2 -> 10 busy cycles; lo=0xFFFFFFFD(-3), hi=0xFFFFFFFF(-1).
//    divu a=7, b=0 -> hi/lo unchanged, done pulses.
//  - mult busy, md_use_E=1 (mflo) -> stall_req=1 every busy cycle, 0 in the cycle after done;
//    mtlo a=0x1234 while IDLE -> lo=0x1234 next edge, busy stays 0.
//  - div start, reset asserted on busy cycle 4 -> busy=0, hi=lo=0 next edge;
//    mult 3*4 issued right after -> lo=12.
//  - (MD_CANCEL_EN) hi=lo=0x55; mult 9*9, cancel on busy cycle 2 -> no done;
//    hi/lo stay 0x55; busy=0 next edge.

Source files
------------

// File: rtl/md_sequencer.sv
// rtl/md_sequencer.sv - multi-cycle mult/div sequencer owning HI/LO; optional abort via MD_CANCEL_EN
module md_sequencer #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        md_use_E,
`ifdef MD_CANCEL_EN
    input  logic        cancel,
`endif
    output logic        busy,
    output logic        stall_req,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);
    localparam int MAXN  = (DIV_CYCLES > MULT_CYCLES) ? DIV_CYCLES : MULT_CYCLES;
    localparam int CNT_W = $clog2(MAXN) + 1;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t           state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic [1:0]       op_q;
    logic [31:0]      a_q, b_q;
    logic             kill, accept_md, accept_mt, finish;
    logic             res_we;
    logic [31:0]      res_hi, res_lo;
    logic [63:0]      prod_s, prod_u;
    logic [31:0]      b_safe;

`ifdef MD_CANCEL_EN
    assign kill = cancel;
`else
    assign kill = 1'b0;
`endif

    assign busy      = (state == BUSY);
    assign stall_req = md_use_E & (busy | (start & (op <= 3'd3)));

    always_comb begin
        state_nx  = state;
        cnt_nx    = cnt;
        accept_md = 1'b0;
        accept_mt = 1'b0;
        finish    = 1'b0;
        case (state)
            IDLE: begin
                if (start && !kill) begin
                    if (op <= 3'd3) begin
                        accept_md = 1'b1;
                        state_nx  = BUSY;
                        cnt_nx    = op[1] ? CNT_W'(DIV_CYCLES - 1) : CNT_W'(MULT_CYCLES - 1);
                    end else if (op == 3'd4 || op == 3'd5) begin
                        accept_mt = 1'b1;
                    end
                end
            end
            BUSY: begin
                // Abort wins over completion in the same cycle.
                if (kill) begin
                    state_nx = IDLE;
                    cnt_nx   = '0;
                end else if (cnt == '0) begin
                    finish   = 1'b1;
                    state_nx = IDLE;
                end else begin
                    cnt_nx = cnt - CNT_W'(1);
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Both products are formed as 64x64 so the low 64 bits are exact.
    assign prod_s = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
    assign prod_u = {32'b0, a_q} * {32'b0, b_q};
    assign b_safe = (b_q == 32'd0) ? 32'd1 : b_q;

    always_comb begin
        res_we = 1'b1;
        res_hi = hi;
        res_lo = lo;
        case (op_q)
            2'd0: {res_hi, res_lo} = prod_s;
            2'd1: {res_hi, res_lo} = prod_u;
            2'd2: begin
                if (b_q == 32'd0) begin
                    res_we = 1'b0;
                end else if (a_q == 32'h8000_0000 && b_q == 32'hFFFF_FFFF) begin
                    res_lo = 32'h8000_0000;
                    res_hi = 32'd0;
                end else begin
                    res_lo = $signed(a_q) / $signed(b_safe);
                    res_hi = $signed(a_q) % $signed(b_safe);
                end
            end
            default: begin
                if (b_q == 32'd0) begin
                    res_we = 1'b0;
                end else begin
                    res_lo = a_q / b_safe;
                    res_hi = a_q % b_safe;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            done  <= 1'b0;
            hi    <= 32'd0;
            lo    <= 32'd0;
            op_q  <= 2'd0;
            a_q   <= 32'd0;
            b_q   <= 32'd0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            done  <= finish;
            if (accept_md) begin
                op_q <= op[1:0];
                a_q  <= a;
                b_q  <= b;
            end
            if (accept_mt) begin
                if (op == 3'd4) hi <= a;
                else            lo <= a;
            end
            if (finish && res_we) begin
                hi <= res_hi;
                lo <= res_lo;
            end
        end
    end
endmodule

// File: tb/tb_md_sequencer.sv
// tb/tb_md_sequencer.sv - vector table plus scoreboard bench for md_sequencer
module tb_md_sequencer;
    logic        clk = 1'b0;
    logic        reset, start, md_use_E;
    logic [2:0]  op;
    logic [31:0] a, b;
    logic        busy, stall_req, done;
    logic [31:0] hi, lo;
`ifdef MD_CANCEL_EN
    logic        cancel;
`endif

    md_sequencer #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .md_use_E(md_use_E),
`ifdef MD_CANCEL_EN
        .cancel(cancel),
`endif
        .busy(busy), .stall_req(stall_req), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a, b, init_hi, init_lo, exp_hi, exp_lo;
        int          cycles;
    } vec_t;

    typedef struct {
        logic [31:0] hi, lo;
    } exp_t;

    vec_t vecs[10];
    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic mt(input logic [2:0] o, input logic [31:0] v);
        start = 1'b1; op = o; a = v; b = 32'd0;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic issue(input logic [2:0] o, input logic [31:0] va, input logic [31:0] vb,
                         input logic [31:0] eh, input logic [31:0] el);
        exp_t e;
        start = 1'b1; op = o; a = va; b = vb;
        @(negedge clk);
        start = 1'b0; op = 3'd6;
        e.hi = eh; e.lo = el;
        sb_q.push_back(e);
    endtask

    task automatic wait_done(input string nm, input int exp_cycles);
        int   bc;
        bit   got;
        exp_t e;
        bc = 0; got = 0;
        for (int i = 0; i < 64; i++) begin
            if (done) begin got = 1; break; end
            if (busy) begin
                bc++;
                if (md_use_E) begin
                    #1 chk({nm, " stall while busy"}, 64'(stall_req), 64'd1);
                end
            end
            @(negedge clk);
        end
        chk({nm, " done seen"}, 64'(got), 64'd1);
        if (got) begin
            chk({nm, " busy cycles"}, 64'(bc), 64'(exp_cycles));
            if (md_use_E) begin
                #1 chk({nm, " stall after done"}, 64'(stall_req), 64'd0);
            end
            e = sb_q.pop_front();
            chk({nm, " hi"}, 64'(hi), 64'(e.hi));
            chk({nm, " lo"}, 64'(lo), 64'(e.lo));
        end else begin
            sb_q.delete();
        end
    endtask

    initial begin
        vecs[0] = '{3'd0, 32'hFFFF_FFFE, 32'd3,          32'h0, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 5};
        vecs[1] = '{3'd1, 32'hFFFF_FFFF, 32'd2,          32'h0, 32'h0, 32'h0000_0001, 32'hFFFF_FFFE, 5};
        vecs[2] = '{3'd2, 32'hFFFF_FFF9, 32'd2,          32'h0, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 10};
        vecs[3] = '{3'd3, 32'd7,         32'd0,          32'hAAAA, 32'hBBBB, 32'hAAAA, 32'hBBBB, 10};
        vecs[4] = '{3'd2, 32'h8000_0000, 32'hFFFF_FFFF,  32'h1, 32'h1, 32'h0, 32'h8000_0000, 10};
        vecs[5] = '{3'd3, 32'd100,       32'd7,          32'h0, 32'h0, 32'd2, 32'd14, 10};
        vecs[6] = '{3'd2, 32'd7,         32'hFFFF_FFFE,  32'h0, 32'h0, 32'd1, 32'hFFFF_FFFD, 10};
        vecs[7] = '{3'd0, 32'h8000_0000, 32'h8000_0000,  32'h0, 32'h0, 32'h4000_0000, 32'h0, 5};
        vecs[8] = '{3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF,  32'h0, 32'h0, 32'hFFFF_FFFE, 32'h1, 5};
        vecs[9] = '{3'd2, 32'd5,         32'd0,          32'h1234, 32'h5678, 32'h1234, 32'h5678, 10};

        reset = 1'b1; start = 1'b0; op = 3'd6; a = 32'd0; b = 32'd0; md_use_E = 1'b0;
`ifdef MD_CANCEL_EN
        cancel = 1'b0;
`endif
        repeat (2) @(negedge clk);
        chk("reset busy", 64'(busy), 64'd0);
        chk("reset done", 64'(done), 64'd0);
        chk("reset hi", 64'(hi), 64'd0);
        chk("reset lo", 64'(lo), 64'd0);
        reset = 1'b0;

        for (int i = 0; i < 10; i++) begin
            mt(3'd4, vecs[i].init_hi);
            mt(3'd5, vecs[i].init_lo);
            issue(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp_hi, vecs[i].exp_lo);
            wait_done($sformatf("vec%0d", i), vecs[i].cycles);
        end

        // Back-to-back issue straight from the done cycle.
        issue(3'd0, 32'd6, 32'd7, 32'd0, 32'd42);
        wait_done("b2b first", 5);
        issue(3'd1, 32'd2, 32'd3, 32'd0, 32'd6);
        wait_done("b2b second", 5);

        // HI/LO user waiting on a mult.
        @(negedge clk);
        md_use_E = 1'b1; start = 1'b1; op = 3'd0; a = 32'd2; b = 32'd5;
        #1 chk("stall on start", 64'(stall_req), 64'd1);
        @(negedge clk);
        start = 1'b0; op = 3'd6;
        sb_q.push_back('{32'd0, 32'd10});
        wait_done("stall mult", 5);
        md_use_E = 1'b0;

        mt(3'd5, 32'h1234);
        chk("mtlo lo", 64'(lo), 64'h1234);
        chk("mtlo busy", 64'(busy), 64'd0);
        chk("mtlo done", 64'(done), 64'd0);

        // Reset on the fourth busy cycle of a div.
        issue(3'd2, 32'd100, 32'd3, 32'd1, 32'd33);
        sb_q.delete();
        repeat (3) @(negedge clk);
        chk("pre-reset busy", 64'(busy), 64'd1);
        reset = 1'b1;
        @(negedge clk);
        chk("mid reset busy", 64'(busy), 64'd0);
        chk("mid reset hi", 64'(hi), 64'd0);
        chk("mid reset lo", 64'(lo), 64'd0);
        reset = 1'b0;
        issue(3'd0, 32'd3, 32'd4, 32'd0, 32'd12);
        wait_done("post reset mult", 5);

`ifdef MD_CANCEL_EN
        mt(3'd4, 32'h55);
        mt(3'd5, 32'h55);
        start = 1'b1; op = 3'd0; a = 32'd9; b = 32'd9;
        @(negedge clk);
        start = 1'b0; op = 3'd6;
        @(negedge clk);
        cancel = 1'b1;
        @(negedge clk);
        cancel = 1'b0;
        chk("cancel busy", 64'(busy), 64'd0);
        chk("cancel done", 64'(done), 64'd0);
        @(negedge clk);
        chk("cancel late done", 64'(done), 64'd0);
        chk("cancel hi", 64'(hi), 64'h55);
        chk("cancel lo", 64'(lo), 64'h55);
        start = 1'b1; op = 3'd5; a = 32'h77; cancel = 1'b1;
        @(negedge clk);
        start = 1'b0; op = 3'd6; cancel = 1'b0;
        chk("cancel mtlo lo", 64'(lo), 64'h55);
        chk("cancel mtlo busy", 64'(busy), 64'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
